// File: rtl/sm_gpio_debounce.sv
// Two-flop synchroniser plus per-bit debounce counter with rise/fall strobes.
// Optional sticky event flags and summary irq when SM_GPIO_DEBOUNCE_EVENT_EN is defined.
module sm_gpio_debounce #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_raw,
    output logic [WIDTH-1:0] gpio_clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] evt,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] accept;
    logic [CNT_W-1:0] cnt [WIDTH];

    // A bit is accepted when it has differed from the clean level for STABLE_CYCLES samples.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync1[i] != clean_q[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0   <= '0;
            sync1   <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync0  <= gpio_raw;
            sync1  <= sync0;
            rise_q <= accept & sync1;
            fall_q <= accept & ~sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync1[i] == clean_q[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    clean_q[i] <= sync1[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign gpio_clean = clean_q;
    assign rise       = rise_q;
    assign fall       = fall_q;

`ifdef SM_GPIO_DEBOUNCE_EVENT_EN
    logic [WIDTH-1:0] evt_q;

    // Set has priority over clear so an edge arriving with a clear is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= (evt_q & ~evt_clr) | accept;
        end
    end

    assign evt = evt_q;
    assign irq = |evt_q;
`else
    logic unused_evt_clr;

    assign unused_evt_clr = ^evt_clr;
    assign evt            = '0;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_sm_gpio_debounce.sv
// Directed bench for sm_gpio_debounce (WIDTH=16, STABLE_CYCLES=4).
// Event checks follow SM_GPIO_DEBOUNCE_EVENT_EN the same way as the design.
module tb_sm_gpio_debounce;

    logic        clk;
    logic        rst;
    logic [15:0] gpio_raw;
    logic [15:0] gpio_clean;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] evt_clr;
    logic [15:0] evt;
    logic        irq;

    int checks;
    int failures;

    sm_gpio_debounce #(
        .WIDTH(16),
        .STABLE_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gpio_raw(gpio_raw),
        .gpio_clean(gpio_clean),
        .rise(rise),
        .fall(fall),
        .evt_clr(evt_clr),
        .evt(evt),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [15:0] value);
        gpio_raw = value;
        repeat (10) tick();
        evt_clr = 16'hFFFF;
        tick();
        evt_clr = 16'h0000;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        gpio_raw = 16'hFFFF;
        evt_clr  = 16'h0000;
        tick();
        tick();
        checks++;
        if (gpio_clean !== 16'h0000 || rise !== 16'h0000 || fall !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs clean=%h rise=%h fall=%h required 0000", gpio_clean, rise, fall);
        end
        checks++;
        if (evt !== 16'h0000 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_evt evt=%h irq=%b required 0000/0", evt, irq);
        end
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6) begin
                checks++;
                if (gpio_clean !== 16'h0000 || rise !== 16'h0000) begin
                    failures++;
                    $display("FAIL reset_release_early e=%0d clean=%h rise=%h required 0000", e, gpio_clean, rise);
                end
            end else begin
                checks++;
                if (gpio_clean !== 16'hFFFF || rise !== 16'hFFFF || fall !== 16'h0000) begin
                    failures++;
                    $display("FAIL reset_release_accept clean=%h rise=%h fall=%h required ffff/ffff/0000", gpio_clean, rise, fall);
                end
            end
        end
        tick();
        checks++;
        if (gpio_clean !== 16'hFFFF || rise !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rise_one_cycle clean=%h rise=%h required ffff/0000", gpio_clean, rise);
        end
    endtask

    task automatic test_step();
        settle(16'h0000);
        gpio_raw = 16'h0001;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (e < 6) begin
                if (gpio_clean !== 16'h0000 || rise !== 16'h0000) begin
                    failures++;
                    $display("FAIL step_early e=%0d clean=%h rise=%h required 0000/0000", e, gpio_clean, rise);
                end
            end else if (gpio_clean !== 16'h0001 || rise !== 16'h0001 || fall !== 16'h0000) begin
                failures++;
                $display("FAIL step_accept clean=%h rise=%h fall=%h required 0001/0001/0000", gpio_clean, rise, fall);
            end
        end
        tick();
        checks++;
        if (gpio_clean !== 16'h0001 || rise !== 16'h0000 || fall !== 16'h0000) begin
            failures++;
            $display("FAIL step_strobe_end clean=%h rise=%h fall=%h required 0001/0000/0000", gpio_clean, rise, fall);
        end
    endtask

    task automatic test_glitch();
        settle(16'h0000);
        gpio_raw = 16'h0008;
        repeat (3) tick();
        gpio_raw = 16'h0000;
        for (int e = 0; e < 8; e++) begin
            checks++;
            if (gpio_clean !== 16'h0000 || rise !== 16'h0000 || evt !== 16'h0000) begin
                failures++;
                $display("FAIL glitch_rejected e=%0d clean=%h rise=%h evt=%h required 0000", e, gpio_clean, rise, evt);
            end
            tick();
        end
        gpio_raw = 16'h0008;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) gpio_raw = 16'h0000;
            if (e == 6) begin
                checks++;
                if (gpio_clean !== 16'h0008 || rise !== 16'h0008) begin
                    failures++;
                    $display("FAIL glitch_long_pulse clean=%h rise=%h required 0008/0008", gpio_clean, rise);
                end
            end
        end
    endtask

    task automatic test_fall_indep();
        settle(16'h0020);
        gpio_raw = 16'h0080;
        repeat (6) tick();
        checks++;
        if (gpio_clean !== 16'h0080 || rise !== 16'h0080 || fall !== 16'h0020) begin
            failures++;
            $display("FAIL fall_indep clean=%h rise=%h fall=%h required 0080/0080/0020", gpio_clean, rise, fall);
        end
    endtask

    task automatic test_reset_mid();
        settle(16'h0000);
        gpio_raw = 16'h0004;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (gpio_clean !== 16'h0000 || rise !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_cleared clean=%h rise=%h required 0000", gpio_clean, rise);
        end
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (e < 6) begin
                if (gpio_clean !== 16'h0000) begin
                    failures++;
                    $display("FAIL reset_mid_early e=%0d clean=%h required 0000", e, gpio_clean);
                end
            end else if (gpio_clean !== 16'h0004 || rise !== 16'h0004) begin
                failures++;
                $display("FAIL reset_mid_accept clean=%h rise=%h required 0004/0004", gpio_clean, rise);
            end
        end
    endtask

`ifdef SM_GPIO_DEBOUNCE_EVENT_EN
    task automatic test_event();
        settle(16'h0000);
        gpio_raw = 16'h0002;
        repeat (6) tick();
        checks++;
        if (evt !== 16'h0002 || irq !== 1'b1 || rise !== 16'h0002) begin
            failures++;
            $display("FAIL event_set evt=%h irq=%b rise=%h required 0002/1/0002", evt, irq, rise);
        end
        gpio_raw = 16'h0000;
        repeat (5) tick();
        evt_clr = 16'h0002;
        tick();
        evt_clr = 16'h0000;
        checks++;
        if (fall !== 16'h0002 || evt !== 16'h0002 || irq !== 1'b1) begin
            failures++;
            $display("FAIL event_set_wins fall=%h evt=%h irq=%b required 0002/0002/1", fall, evt, irq);
        end
        evt_clr = 16'h0002;
        tick();
        evt_clr = 16'h0000;
        checks++;
        if (evt !== 16'h0000 || irq !== 1'b0) begin
            failures++;
            $display("FAIL event_clear evt=%h irq=%b required 0000/0", evt, irq);
        end
    endtask
`else
    task automatic test_event();
        settle(16'h0000);
        gpio_raw = 16'h0002;
        repeat (6) tick();
        checks++;
        if (evt !== 16'h0000 || irq !== 1'b0 || rise !== 16'h0002) begin
            failures++;
            $display("FAIL event_disabled evt=%h irq=%b rise=%h required 0000/0/0002", evt, irq, rise);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        gpio_raw = 16'h0000;
        evt_clr  = 16'h0000;
        test_reset();
        test_step();
        test_glitch();
        test_fall_indep();
        test_reset_mid();
        test_event();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
